tlink_uncached_tracker: RTL and testbench

- Manager-side TileLink transaction tracker for uncached accesses.
- Consumes Acquire beats, runs one single-beat access on a simple memory port, returns the Grant, then holds until the client's Finish retires the transaction.
- Sits directly downstream of the client's Acquire channel and upstream of its Grant/Finish channels.
- One transaction in flight at a time; no reordering.

---
 rtl/tlink_uncached_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_tlink_uncached_tracker.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlink_uncached_tracker.sv
// Manager-side TileLink tracker: one uncached single-beat access per Acquire, Grant, then Finish.
// Optional macro TLINK_TRACKER_FINISH_EN keeps the FINISH state; without it the Grant handshake retires.
module tlink_uncached_tracker #(
  parameter int unsigned          ADDR_BITS = 32,
  parameter int unsigned          DATA_BITS = 64,
  parameter int unsigned          CXID_BITS = 4,
  parameter int unsigned          MXID_BITS = 2,
  parameter int unsigned          EP_BITS   = 2,
  parameter logic [MXID_BITS-1:0] MY_MXID   = '0,
  parameter logic [2:0]           ACQ_RD    = 3'd2,
  parameter logic [2:0]           ACQ_WR    = 3'd4,
  parameter logic [3:0]           GNT_RD    = 4'd3,
  parameter logic [3:0]           GNT_WR    = 4'd4,
  parameter logic [3:0]           GNT_ERR   = 4'd15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 acq_valid,
  output logic                 acq_ready,
  input  logic [EP_BITS-1:0]   acq_src,
  input  logic [EP_BITS-1:0]   acq_dst,
  input  logic [ADDR_BITS-1:0] acq_addr,
  input  logic [CXID_BITS-1:0] acq_client_xact_id,
  input  logic [DATA_BITS-1:0] acq_data,
  input  logic                 acq_uncached,
  input  logic [2:0]           acq_a_type,
  input  logic [7:0]           acq_subblock,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [DATA_BITS-1:0] mem_req_wdata,
  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_rdata,
  output logic                 gnt_valid,
  input  logic                 gnt_ready,
  output logic [EP_BITS-1:0]   gnt_src,
  output logic [EP_BITS-1:0]   gnt_dst,
  output logic [CXID_BITS-1:0] gnt_client_xact_id,
  output logic [MXID_BITS-1:0] gnt_manager_xact_id,
  output logic [DATA_BITS-1:0] gnt_data,
  output logic [3:0]           gnt_g_type,
  input  logic                 fin_valid,
  output logic                 fin_ready,
  input  logic [EP_BITS-1:0]   fin_dst,
  input  logic [MXID_BITS-1:0] fin_manager_xact_id
);

  // state      | meaning
  // S_IDLE     | accepting an Acquire
  // S_MEM_REQ  | presenting the memory request until accepted
  // S_MEM_RESP | waiting for the single memory response
  // S_GRANT    | presenting the Grant until accepted
  // S_FINISH   | waiting for the matching Finish (macro builds only)
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_REQ  = 3'd1,
    S_MEM_RESP = 3'd2,
    S_GRANT    = 3'd3
`ifdef TLINK_TRACKER_FINISH_EN
    , S_FINISH = 3'd4
`endif
  } state_e;

  state_e state_q, state_d;

  logic                 acq_ready_q, acq_ready_d;
  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_req_we_q, mem_req_we_d;
  logic [ADDR_BITS-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_BITS-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [EP_BITS-1:0]   gnt_src_q, gnt_src_d;
  logic [EP_BITS-1:0]   gnt_dst_q, gnt_dst_d;
  logic [CXID_BITS-1:0] gnt_cxid_q, gnt_cxid_d;
  logic [MXID_BITS-1:0] gnt_mxid_q, gnt_mxid_d;
  logic [DATA_BITS-1:0] gnt_data_q, gnt_data_d;
  logic [3:0]           gnt_type_q, gnt_type_d;
  logic                 fin_ready_q, fin_ready_d;

  logic acq_fire, acq_ok, acq_is_wr, mem_fire, gnt_fire;
  logic unused_inputs;

  assign acq_fire  = acq_valid & acq_ready_q;
  assign acq_is_wr = (acq_a_type == ACQ_WR);
  assign acq_ok    = acq_uncached & ((acq_a_type == ACQ_RD) | acq_is_wr);
  assign mem_fire  = mem_req_valid_q & mem_req_ready;
  assign gnt_fire  = gnt_valid_q & gnt_ready;

`ifdef TLINK_TRACKER_FINISH_EN
  logic fin_match;
  // gnt_src_q holds the latched acq_dst, which is what a Finish must be addressed to
  assign fin_match     = fin_valid & fin_ready_q & (fin_manager_xact_id == MY_MXID) &
                         (fin_dst == gnt_src_q);
  assign unused_inputs = ^acq_subblock;
`else
  assign unused_inputs = ^{acq_subblock, fin_valid, fin_dst, fin_manager_xact_id};
`endif

  always_comb begin
    state_d         = state_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    gnt_src_d       = gnt_src_q;
    gnt_dst_d       = gnt_dst_q;
    gnt_cxid_d      = gnt_cxid_q;
    gnt_mxid_d      = gnt_mxid_q;
    gnt_data_d      = gnt_data_q;
    gnt_type_d      = gnt_type_q;

    case (state_q)
      S_IDLE: begin
        if (acq_fire) begin
          mem_req_we_d    = acq_ok & acq_is_wr;
          mem_req_addr_d  = acq_addr;
          mem_req_wdata_d = acq_data;
          gnt_src_d       = acq_dst;
          gnt_dst_d       = acq_src;
          gnt_cxid_d      = acq_client_xact_id;
          gnt_mxid_d      = MY_MXID;
          gnt_data_d      = '0;
          if (!acq_ok)        gnt_type_d = GNT_ERR;
          else if (acq_is_wr) gnt_type_d = GNT_WR;
          else                gnt_type_d = GNT_RD;
          state_d = acq_ok ? S_MEM_REQ : S_GRANT;
        end
      end
      S_MEM_REQ: begin
        if (mem_fire) state_d = S_MEM_RESP;
      end
      S_MEM_RESP: begin
        if (mem_resp_valid) begin
          gnt_data_d = mem_req_we_q ? '0 : mem_resp_rdata;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
`ifdef TLINK_TRACKER_FINISH_EN
        if (gnt_fire) state_d = S_FINISH;
`else
        if (gnt_fire) state_d = S_IDLE;
`endif
      end
`ifdef TLINK_TRACKER_FINISH_EN
      S_FINISH: begin
        if (fin_match) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    acq_ready_d     = (state_d == S_IDLE);
    mem_req_valid_d = (state_d == S_MEM_REQ);
    gnt_valid_d     = (state_d == S_GRANT);
`ifdef TLINK_TRACKER_FINISH_EN
    fin_ready_d     = (state_d == S_FINISH);
`else
    fin_ready_d     = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      acq_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      gnt_valid_q     <= 1'b0;
      gnt_src_q       <= '0;
      gnt_dst_q       <= '0;
      gnt_cxid_q      <= '0;
      gnt_mxid_q      <= '0;
      gnt_data_q      <= '0;
      gnt_type_q      <= '0;
      fin_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      acq_ready_q     <= acq_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      gnt_valid_q     <= gnt_valid_d;
      gnt_src_q       <= gnt_src_d;
      gnt_dst_q       <= gnt_dst_d;
      gnt_cxid_q      <= gnt_cxid_d;
      gnt_mxid_q      <= gnt_mxid_d;
      gnt_data_q      <= gnt_data_d;
      gnt_type_q      <= gnt_type_d;
      fin_ready_q     <= fin_ready_d;
    end
  end

  assign acq_ready           = acq_ready_q;
  assign mem_req_valid       = mem_req_valid_q;
  assign mem_req_we          = mem_req_we_q;
  assign mem_req_addr        = mem_req_addr_q;
  assign mem_req_wdata       = mem_req_wdata_q;
  assign gnt_valid           = gnt_valid_q;
  assign gnt_src             = gnt_src_q;
  assign gnt_dst             = gnt_dst_q;
  assign gnt_client_xact_id  = gnt_cxid_q;
  assign gnt_manager_xact_id = gnt_mxid_q;
  assign gnt_data            = gnt_data_q;
  assign gnt_g_type          = gnt_type_q;
  assign fin_ready           = fin_ready_q;

endmodule

// File: tb/tb_tlink_uncached_tracker.sv
// Self-checking bench for tlink_uncached_tracker: directed scenarios plus randomized traffic
// compared against a transaction-level reference model; follows TLINK_TRACKER_FINISH_EN.
module tb_tlink_uncached_tracker;
  localparam int AB = 32, DB = 64, CB = 4, MB = 2, EB = 2;
  localparam logic [MB-1:0] MXID  = '0;
  localparam logic [2:0]    A_RD  = 3'd2;
  localparam logic [2:0]    A_WR  = 3'd4;
  localparam logic [3:0]    G_RD  = 4'd3;
  localparam logic [3:0]    G_WR  = 4'd4;
  localparam logic [3:0]    G_ERR = 4'd15;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          acq_valid, acq_ready;
  logic [EB-1:0] acq_src, acq_dst;
  logic [AB-1:0] acq_addr;
  logic [CB-1:0] acq_client_xact_id;
  logic [DB-1:0] acq_data;
  logic          acq_uncached;
  logic [2:0]    acq_a_type;
  logic [7:0]    acq_subblock;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DB-1:0] mem_resp_rdata;
  logic          gnt_valid, gnt_ready;
  logic [EB-1:0] gnt_src, gnt_dst;
  logic [CB-1:0] gnt_client_xact_id;
  logic [MB-1:0] gnt_manager_xact_id;
  logic [DB-1:0] gnt_data;
  logic [3:0]    gnt_g_type;
  logic          fin_valid, fin_ready;
  logic [EB-1:0] fin_dst;
  logic [MB-1:0] fin_manager_xact_id;

  always #5 clk = ~clk;

  tlink_uncached_tracker dut (
    .clk(clk), .rstn(rstn),
    .acq_valid(acq_valid), .acq_ready(acq_ready),
    .acq_src(acq_src), .acq_dst(acq_dst), .acq_addr(acq_addr),
    .acq_client_xact_id(acq_client_xact_id), .acq_data(acq_data),
    .acq_uncached(acq_uncached), .acq_a_type(acq_a_type), .acq_subblock(acq_subblock),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_src(gnt_src), .gnt_dst(gnt_dst),
    .gnt_client_xact_id(gnt_client_xact_id), .gnt_manager_xact_id(gnt_manager_xact_id),
    .gnt_data(gnt_data), .gnt_g_type(gnt_g_type),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .fin_dst(fin_dst),
    .fin_manager_xact_id(fin_manager_xact_id)
  );

  int checks = 0;
  int errors = 0;

  // mem_dev is the memory the DUT talks to; ref_mem is the model's view built from Acquires.
  logic [DB-1:0] mem_dev [logic [AB-1:0]];
  logic [DB-1:0] ref_mem [logic [AB-1:0]];

  typedef struct packed {
    logic [EB-1:0] src;
    logic [EB-1:0] dst;
    logic [AB-1:0] addr;
    logic [CB-1:0] cxid;
    logic [DB-1:0] data;
    logic          unc;
    logic [2:0]    atype;
  } acq_t;

  typedef struct packed {
    bit            timeout;
    int            wait_cyc;
    bit            acq_drop;
    bit            req_now;
    bit            mem_seen;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata;
    bit            req_stable;
    bit            gnt_now;
    logic [EB-1:0] gnt_src;
    logic [EB-1:0] gnt_dst;
    logic [CB-1:0] gnt_cxid;
    logic [MB-1:0] gnt_mxid;
    logic [DB-1:0] gnt_data;
    logic [3:0]    gnt_type;
    bit            gnt_stable;
    bit            fin_ready_seen;
    bit            bad_fin_hold;
    bit            post_ready;
  } obs_t;

  function automatic logic [DB-1:0] dflt(input logic [AB-1:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation: what the Grant must carry for this Acquire.
  task automatic model(input acq_t a, output bit exp_mem, output logic exp_we,
                       output logic [3:0] exp_type, output logic [DB-1:0] exp_data);
    exp_mem = a.unc && (a.atype == A_RD || a.atype == A_WR);
    exp_we  = exp_mem && (a.atype == A_WR);
    if (!exp_mem) begin
      exp_type = G_ERR;
      exp_data = '0;
    end else if (exp_we) begin
      exp_type = G_WR;
      exp_data = '0;
      ref_mem[a.addr] = a.data;
    end else begin
      exp_type = G_RD;
      exp_data = ref_mem.exists(a.addr) ? ref_mem[a.addr] : dflt(a.addr);
    end
  endtask

  // Drives one full transaction and records what the DUT did; performs no checking.
  task automatic run_txn(input acq_t a, input int req_stall, input int resp_lat,
                         input int gnt_stall, input int fin_mode, output obs_t o);
    logic [DB-1:0] rd;
    int w;
    o = '0;
    while (!acq_ready && o.wait_cyc < 50) begin
      tick();
      o.wait_cyc++;
    end
    if (!acq_ready) begin
      o.timeout = 1;
      return;
    end
    acq_valid = 1; acq_src = a.src; acq_dst = a.dst; acq_addr = a.addr;
    acq_client_xact_id = a.cxid; acq_data = a.data; acq_uncached = a.unc;
    acq_a_type = a.atype; acq_subblock = 8'($urandom);
    tick();
    acq_valid = 0; acq_src = EB'($urandom); acq_dst = EB'($urandom); acq_addr = $urandom;
    acq_client_xact_id = CB'($urandom); acq_data = {$urandom, $urandom};
    o.acq_drop = !acq_ready;
    o.req_now  = mem_req_valid;
    o.mem_seen = mem_req_valid;
    o.gnt_now  = gnt_valid;
    if (mem_req_valid) begin
      o.mem_we = mem_req_we; o.mem_addr = mem_req_addr; o.mem_wdata = mem_req_wdata;
      o.req_stable = 1;
      for (int i = 0; i < req_stall; i++) begin
        tick();
        if (!mem_req_valid || mem_req_we !== o.mem_we || mem_req_addr !== o.mem_addr ||
            mem_req_wdata !== o.mem_wdata) o.req_stable = 0;
      end
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      if (o.mem_we) begin
        mem_dev[o.mem_addr] = o.mem_wdata;
        rd = {$urandom, $urandom};
      end else begin
        rd = mem_dev.exists(o.mem_addr) ? mem_dev[o.mem_addr] : dflt(o.mem_addr);
      end
      for (int i = 0; i < resp_lat; i++) tick();
      mem_resp_valid = 1; mem_resp_rdata = rd;
      tick();
      mem_resp_valid = 0; mem_resp_rdata = {$urandom, $urandom};
      o.gnt_now = gnt_valid;
    end
    w = 0;
    while (!gnt_valid && w < 50) begin
      tick();
      w++;
      if (mem_req_valid) o.mem_seen = 1;
    end
    if (!gnt_valid) begin
      o.timeout = 1;
      return;
    end
    o.gnt_src = gnt_src; o.gnt_dst = gnt_dst; o.gnt_cxid = gnt_client_xact_id;
    o.gnt_mxid = gnt_manager_xact_id; o.gnt_data = gnt_data; o.gnt_type = gnt_g_type;
    o.gnt_stable = 1;
    for (int i = 0; i < gnt_stall; i++) begin
      mem_resp_valid = 1; mem_resp_rdata = {$urandom, $urandom};
      tick();
      if (!gnt_valid || gnt_src !== o.gnt_src || gnt_dst !== o.gnt_dst ||
          gnt_client_xact_id !== o.gnt_cxid || gnt_manager_xact_id !== o.gnt_mxid ||
          gnt_data !== o.gnt_data || gnt_g_type !== o.gnt_type) o.gnt_stable = 0;
    end
    mem_resp_valid = 0;
    gnt_ready = 1;
    tick();
    gnt_ready = 0;
    if (mem_req_valid) o.mem_seen = 1;
    o.fin_ready_seen = fin_ready;
    o.bad_fin_hold = 1;
`ifdef TLINK_TRACKER_FINISH_EN
    if (fin_mode == 1) begin
      for (int j = 0; j < 2; j++) begin
        fin_valid = 1;
        fin_dst = (j == 0) ? a.dst : (a.dst ^ EB'(1));
        fin_manager_xact_id = (j == 0) ? (MXID ^ MB'(1)) : MXID;
        tick();
        fin_valid = 0;
        if (acq_ready || !fin_ready || gnt_valid) o.bad_fin_hold = 0;
        tick();
        if (acq_ready || !fin_ready || gnt_valid) o.bad_fin_hold = 0;
      end
    end
    fin_valid = 1; fin_dst = a.dst; fin_manager_xact_id = MXID;
    tick();
    fin_valid = 0;
    o.post_ready = acq_ready;
`else
    o.post_ready = acq_ready;
    if (fin_mode == 1) begin
      fin_valid = 1; fin_dst = a.dst; fin_manager_xact_id = MXID;
      tick();
      fin_valid = 0;
      if (!acq_ready || !fin_ready || gnt_valid) o.bad_fin_hold = 0;
    end
`endif
  endtask

  task automatic test_reset();
    logic [176:0] outs;
    repeat (3) tick();
    outs = {mem_req_valid, gnt_valid, mem_req_we, mem_req_addr, mem_req_wdata, gnt_src, gnt_dst,
            gnt_client_xact_id, gnt_manager_xact_id, gnt_data, gnt_g_type};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", outs);
    end
    checks++;
    if (acq_ready !== 1'b0) begin
      errors++; $display("FAIL reset_acq_ready got %b exp 0", acq_ready);
    end
`ifdef TLINK_TRACKER_FINISH_EN
    checks++;
    if (fin_ready !== 1'b0) begin
      errors++; $display("FAIL reset_fin_ready got %b exp 0", fin_ready);
    end
`endif
    rstn = 1;
    #2;
    checks++;
    if (acq_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_before_edge got %b exp 0", acq_ready);
    end
    tick();
    checks++;
    if ({acq_ready, mem_req_valid, gnt_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_first_edge got %b exp 100", {acq_ready, mem_req_valid, gnt_valid});
    end
`ifndef TLINK_TRACKER_FINISH_EN
    checks++;
    if (fin_ready !== 1'b1) begin
      errors++; $display("FAIL reset_fin_tied got %b exp 1", fin_ready);
    end
`endif
  endtask

  task automatic test_read();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    mem_dev[32'h100] = 64'hDEADBEEF;
    ref_mem[32'h100] = 64'hDEADBEEF;
    a = '{src: 2'd1, dst: 2'd2, addr: 32'h100, cxid: 4'd3, data: 64'h0, unc: 1'b1, atype: A_RD};
    model(a, em, ewe, et, ed);
    run_txn(a, 0, 2, 0, 0, o);
    checks++;
    if (o.timeout !== 1'b0) begin errors++; $display("FAIL read_timeout got 1 exp 0"); end
    checks++;
    if ({o.acq_drop, o.req_now, o.mem_we} !== 3'b110) begin
      errors++; $display("FAIL read_req_timing got %b exp 110", {o.acq_drop, o.req_now, o.mem_we});
    end
    checks++;
    if (o.mem_addr !== 32'h100) begin errors++; $display("FAIL read_addr got %h exp 100", o.mem_addr); end
    checks++;
    if (o.gnt_now !== 1'b1) begin errors++; $display("FAIL read_gnt_latency got %b exp 1", o.gnt_now); end
    checks++;
    if (o.gnt_type !== G_RD) begin errors++; $display("FAIL read_gtype got %h exp %h", o.gnt_type, G_RD); end
    checks++;
    if (o.gnt_data !== 64'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", o.gnt_data); end
    checks++;
    if ({o.gnt_cxid, o.gnt_mxid, o.gnt_dst, o.gnt_src} !== {4'd3, MXID, 2'd1, 2'd2}) begin
      errors++; $display("FAIL read_header got %h exp %h", {o.gnt_cxid, o.gnt_mxid, o.gnt_dst, o.gnt_src},
                         {4'd3, MXID, 2'd1, 2'd2});
    end
    checks++;
    if (o.post_ready !== 1'b1) begin errors++; $display("FAIL read_retire got %b exp 1", o.post_ready); end
`ifndef TLINK_TRACKER_FINISH_EN
    checks++;
    if (o.fin_ready_seen !== 1'b1) begin errors++; $display("FAIL read_fin_tied got %b exp 1", o.fin_ready_seen); end
`endif
  endtask

  task automatic test_write();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    a = '{src: 2'd3, dst: 2'd0, addr: 32'h200, cxid: 4'd7, data: 64'h55AA, unc: 1'b1, atype: A_WR};
    model(a, em, ewe, et, ed);
    run_txn(a, 3, 1, 0, 0, o);
    checks++;
    if (o.req_stable !== 1'b1) begin errors++; $display("FAIL write_req_stable got %b exp 1", o.req_stable); end
    checks++;
    if ({o.mem_we, o.mem_addr, o.mem_wdata} !== {1'b1, 32'h200, 64'h55AA}) begin
      errors++; $display("FAIL write_req got %h exp %h", {o.mem_we, o.mem_addr, o.mem_wdata}, {1'b1, 32'h200, 64'h55AA});
    end
    checks++;
    if ({o.gnt_type, o.gnt_data} !== {G_WR, 64'h0}) begin
      errors++; $display("FAIL write_grant got %h exp %h", {o.gnt_type, o.gnt_data}, {G_WR, 64'h0});
    end
  endtask

  task automatic test_error();
    acq_t a;
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      a = '{src: 2'd2, dst: 2'd1, addr: 32'h80, cxid: 4'(k + 10), data: 64'h1234,
            unc: (k == 1), atype: (k == 0) ? A_RD : 3'd0};
      run_txn(a, 0, 0, 1, 0, o);
      checks++;
      if ({o.mem_seen, o.gnt_now} !== 2'b01) begin
        errors++; $display("FAIL error_path_%0d got mem/gnt %b exp 01", k, {o.mem_seen, o.gnt_now});
      end
      checks++;
      if ({o.gnt_type, o.gnt_data, o.gnt_cxid} !== {G_ERR, 64'h0, 4'(k + 10)}) begin
        errors++; $display("FAIL error_grant_%0d got %h exp %h", k, {o.gnt_type, o.gnt_data, o.gnt_cxid},
                           {G_ERR, 64'h0, 4'(k + 10)});
      end
    end
  endtask

  task automatic test_gnt_backpressure_finish();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    a = '{src: 2'd0, dst: 2'd3, addr: 32'h200, cxid: 4'd12, data: 64'h0, unc: 1'b1, atype: A_RD};
    model(a, em, ewe, et, ed);
    run_txn(a, 1, 0, 5, 1, o);
    checks++;
    if (o.gnt_stable !== 1'b1) begin errors++; $display("FAIL bp_gnt_stable got %b exp 1", o.gnt_stable); end
    checks++;
    if (o.gnt_data !== ed) begin errors++; $display("FAIL bp_data got %h exp %h", o.gnt_data, ed); end
    checks++;
    if (o.fin_ready_seen !== 1'b1) begin errors++; $display("FAIL bp_fin_ready got %b exp 1", o.fin_ready_seen); end
    checks++;
    if (o.bad_fin_hold !== 1'b1) begin errors++; $display("FAIL bp_finish_filter got %b exp 1", o.bad_fin_hold); end
    checks++;
    if (o.post_ready !== 1'b1) begin errors++; $display("FAIL bp_retire got %b exp 1", o.post_ready); end
  endtask

  task automatic test_reset_mid();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    int w;
    w = 0;
    while (!acq_ready && w < 50) begin tick(); w++; end
    acq_valid = 1; acq_uncached = 0; acq_a_type = A_RD; acq_addr = 32'h40;
    acq_client_xact_id = 4'd9; acq_src = 2'd0; acq_dst = 2'd1;
    tick();
    acq_valid = 0;
    checks++;
    if (gnt_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_grant got %b exp 1", gnt_valid); end
    #2 rstn = 0;
    #1;
    checks++;
    if ({acq_ready, mem_req_valid, gnt_valid, gnt_g_type, gnt_client_xact_id} !== '0) begin
      errors++; $display("FAIL rst_mid_grant_drop got %h exp 0",
                         {acq_ready, mem_req_valid, gnt_valid, gnt_g_type, gnt_client_xact_id});
    end
    #2 rstn = 1;
    tick();
    checks++;
    if (acq_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_grant_idle got %b exp 1", acq_ready); end
    acq_valid = 1; acq_uncached = 1; acq_a_type = A_RD; acq_addr = 32'h300;
    acq_client_xact_id = 4'd5; acq_src = 2'd1; acq_dst = 2'd2;
    tick();
    acq_valid = 0;
    checks++;
    if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_memreq got %b exp 1", mem_req_valid); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    tick();
    #2 rstn = 0;
    #1;
    checks++;
    if ({acq_ready, mem_req_valid, gnt_valid, mem_req_addr, gnt_data, gnt_client_xact_id} !== '0) begin
      errors++; $display("FAIL rst_mid_resp_drop got %h exp 0",
                         {acq_ready, mem_req_valid, gnt_valid, mem_req_addr, gnt_data, gnt_client_xact_id});
    end
    #2 rstn = 1;
    mem_resp_valid = 1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_resp_valid = 0;
    tick();
    checks++;
    if ({gnt_valid, mem_req_valid, acq_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_late_resp got %b exp 001", {gnt_valid, mem_req_valid, acq_ready});
    end
    a = '{src: 2'd1, dst: 2'd2, addr: 32'h300, cxid: 4'd5, data: 64'h0, unc: 1'b1, atype: A_RD};
    model(a, em, ewe, et, ed);
    run_txn(a, 0, 1, 0, 0, o);
    checks++;
    if ({o.timeout, o.gnt_type, o.gnt_data, o.gnt_cxid} !== {1'b0, et, ed, 4'd5}) begin
      errors++; $display("FAIL rst_mid_recover got %h exp %h", {o.timeout, o.gnt_type, o.gnt_data, o.gnt_cxid},
                         {1'b0, et, ed, 4'd5});
    end
  endtask

  task automatic test_back_to_back();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    for (int k = 0; k < 3; k++) begin
      a = '{src: EB'(k), dst: EB'(k + 1), addr: 32'h400 + 32'(k * 8), cxid: CB'(k),
            data: {$urandom, $urandom}, unc: 1'b1, atype: (k == 1) ? A_RD : A_WR};
      if (k == 1) a.addr = 32'h400;
      model(a, em, ewe, et, ed);
      run_txn(a, 0, 0, 0, 0, o);
      checks++;
      if ({o.wait_cyc, o.post_ready, o.gnt_type, o.gnt_data} !== {32'd0, 1'b1, et, ed}) begin
        errors++; $display("FAIL b2b_%0d got wait %0d ready %b type %h data %h exp wait 0 ready 1 type %h data %h",
                           k, o.wait_cyc, o.post_ready, o.gnt_type, o.gnt_data, et, ed);
      end
    end
  endtask

  task automatic test_random();
    acq_t a;
    obs_t o;
    bit em; logic ewe; logic [3:0] et; logic [DB-1:0] ed;
    int sel;
    for (int n = 0; n < 40; n++) begin
      a.src = EB'($urandom); a.dst = EB'($urandom); a.cxid = CB'($urandom);
      a.addr = 32'h1000 + 32'($urandom_range(0, 7) * 8);
      a.data = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        a.unc = 0; a.atype = 3'($urandom);
      end else if (sel == 1) begin
        a.unc = 1; a.atype = 3'($urandom);
      end else begin
        a.unc = 1; a.atype = $urandom_range(0, 1) ? A_RD : A_WR;
      end
      model(a, em, ewe, et, ed);
      run_txn(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), o);
      checks++;
      if ({o.timeout, o.mem_seen, o.req_now, o.gnt_stable, o.post_ready, o.bad_fin_hold} !==
          {1'b0, em, em, 1'b1, 1'b1, 1'b1}) begin
        errors++; $display("FAIL rand_%0d_flow got %b exp %b", n,
                           {o.timeout, o.mem_seen, o.req_now, o.gnt_stable, o.post_ready, o.bad_fin_hold},
                           {1'b0, em, em, 1'b1, 1'b1, 1'b1});
      end
      if (em) begin
        checks++;
        if ({o.req_stable, o.mem_we, o.mem_addr} !== {1'b1, ewe, a.addr} ||
            (ewe && o.mem_wdata !== a.data)) begin
          errors++; $display("FAIL rand_%0d_memreq got %h wdata %h exp %h wdata %h", n,
                             {o.req_stable, o.mem_we, o.mem_addr}, o.mem_wdata, {1'b1, ewe, a.addr}, a.data);
        end
      end
      checks++;
      if ({o.gnt_type, o.gnt_data} !== {et, ed}) begin
        errors++; $display("FAIL rand_%0d_grant got %h exp %h", n, {o.gnt_type, o.gnt_data}, {et, ed});
      end
      checks++;
      if ({o.gnt_cxid, o.gnt_mxid, o.gnt_dst, o.gnt_src} !== {a.cxid, MXID, a.src, a.dst}) begin
        errors++; $display("FAIL rand_%0d_header got %h exp %h", n, {o.gnt_cxid, o.gnt_mxid, o.gnt_dst, o.gnt_src},
                           {a.cxid, MXID, a.src, a.dst});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    acq_valid = 0; acq_src = '0; acq_dst = '0; acq_addr = '0; acq_client_xact_id = '0;
    acq_data = '0; acq_uncached = 0; acq_a_type = '0; acq_subblock = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    gnt_ready = 0; fin_valid = 0; fin_dst = '0; fin_manager_xact_id = '0;
    test_reset();
    test_read();
    test_write();
    test_error();
    test_gnt_backpressure_finish();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
